// File: rtl/jt89_wr_queue.sv
// jt89_wr_queue
//   Write buffer in front of the jt89 PSG. Single-cycle bus write strobes are
//   queued in a FIFO and replayed to the PSG one at a time. Each replay is a
//   clean psg_wr_n low pulse with psg_din held stable. Every pulse is framed
//   by high time, so back-to-back bus writes are never merged or lost at the
//   PSG's falling-edge latch.
//
// Parameters
//   AW     FIFO address width, depth = 2**AW entries
//   PULSE  psg_wr_n low time in clk cycles (>=1)
//   GAP    psg_wr_n high time after each pulse in clk cycles (>=1)
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   cpu_we    write strobe, one byte accepted per cycle it is high
//   cpu_din   write data, sampled with cpu_we
//   ovf_clr   clears the sticky overflow flag
//   psg_wr_n  registered write strobe to jt89
//   psg_din   registered data to jt89
//   level     FIFO occupancy, 0..2**AW
//   empty     level == 0
//   full      level == 2**AW
//   overflow  sticky: a write arrived while the FIFO was full and was dropped

module jt89_wr_queue #(
  parameter int AW    = 3,
  parameter int PULSE = 2,
  parameter int GAP   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_din,
  input  logic          ovf_clr,
  output logic          psg_wr_n,
  output logic [7:0]    psg_din,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (PULSE > GAP) ? PULSE : GAP;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, LOW, HIGH} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          wr_n_reg, wr_n_next;
  logic [7:0]    din_reg;
  logic          ovf_reg;
  logic          push, pop;

  // full/empty come from the registered level, i.e. the occupancy at the
  // start of the cycle. A byte pushed this cycle therefore cannot be popped
  // until the next one, and a pop in the same cycle does not make room for
  // a write that finds the queue full.
  assign full     = (level_reg == LVL_FULL);
  assign empty    = (level_reg == '0);
  assign push     = cpu_we & ~full;

  assign level    = level_reg;
  assign psg_wr_n = wr_n_reg;
  assign psg_din  = din_reg;
  assign overflow = ovf_reg;

  // Next-state logic for the PSG write sequencer.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_n_next  = wr_n_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_n_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        // psg_din has been stable for one cycle; start the low phase.
        wr_n_next  = 1'b0;
        cnt_next   = CW'(PULSE - 1);
        state_next = LOW;
      end
      LOW: begin
        wr_n_next = 1'b0;
        if (cnt_reg == '0) begin
          wr_n_next  = 1'b1;
          cnt_next   = CW'(GAP - 1);
          state_next = HIGH;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      HIGH: begin
        wr_n_next = 1'b1;
        if (cnt_reg == '0) begin
          // Chain straight into the next byte to keep the 1+PULSE+GAP cadence.
          if (!empty) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        wr_n_next  = 1'b1;
      end
    endcase
  end

  // FIFO storage: no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      wr_n_reg   <= 1'b1;
      din_reg    <= 8'h00;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_n_reg  <= wr_n_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      // The head byte is read straight into the output register, so psg_din
      // only ever changes on a pop edge, which is always a high phase.
      if (pop) begin
        din_reg    <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase

      // A dropped write wins over a clear in the same cycle.
      if (cpu_we && full) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt89_wr_queue.sv
// Testbench for jt89_wr_queue: a default-parameter instance and a
// PULSE=1/GAP=1 instance. A jt89-style monitor on each instance latches
// psg_din on every psg_wr_n falling edge and compares it against a
// scoreboard of bytes the bench expects to be accepted.

module tb_jt89_wr_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       psg_wr_n;
  logic [7:0] psg_din;
  logic [3:0] level;
  logic       empty, full, overflow;

  logic       cpu_we2 = 1'b0;
  logic [7:0] cpu_din2 = 8'h00;
  logic       ovf_clr2 = 1'b0;
  logic       psg_wr_n2;
  logic [7:0] psg_din2;
  logic [3:0] level2;
  logic       empty2, full2, overflow2;

  jt89_wr_queue #(.AW(3), .PULSE(2), .GAP(2)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_din(cpu_din), .ovf_clr(ovf_clr),
    .psg_wr_n(psg_wr_n), .psg_din(psg_din), .level(level), .empty(empty),
    .full(full), .overflow(overflow)
  );

  jt89_wr_queue #(.AW(3), .PULSE(1), .GAP(1)) dut_fast (
    .clk(clk), .rst(rst), .cpu_we(cpu_we2), .cpu_din(cpu_din2), .ovf_clr(ovf_clr2),
    .psg_wr_n(psg_wr_n2), .psg_din(psg_din2), .level(level2), .empty(empty2),
    .full(full2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  logic [7:0] sb2[$];
  int falls[$];
  int falls2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // jt89 model + pulse-shape monitor, default instance
  logic       prev_n = 1'b1;
  int         low_cnt = 0;
  logic [7:0] held = 8'h00;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_n  = 1'b1;
      low_cnt = 0;
    end else begin
      if (prev_n && !psg_wr_n) begin
        falls.push_back(cyc);
        low_cnt = 1;
        held    = psg_din;
        $display("pulse dut      din=%02h cyc=%0d", psg_din, cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got din 0x%02h expected no pulse", psg_din);
        end else begin
          chk("dut_din_order", {24'd0, psg_din}, {24'd0, sb.pop_front()});
        end
      end else if (!prev_n && !psg_wr_n) begin
        low_cnt++;
        chk("dut_din_stable_low", {24'd0, psg_din}, {24'd0, held});
      end else if (!prev_n && psg_wr_n) begin
        chk("dut_low_width", low_cnt, 2);
      end
      prev_n = psg_wr_n;
    end
  end

  // jt89 model + pulse-shape monitor, PULSE=1/GAP=1 instance
  logic       prev_n2 = 1'b1;
  int         low_cnt2 = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_n2  = 1'b1;
      low_cnt2 = 0;
    end else begin
      if (prev_n2 && !psg_wr_n2) begin
        falls2.push_back(cyc);
        low_cnt2 = 1;
        $display("pulse dut_fast din=%02h cyc=%0d", psg_din2, cyc);
        if (sb2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse_fast: got din 0x%02h expected no pulse", psg_din2);
        end else begin
          chk("fast_din_order", {24'd0, psg_din2}, {24'd0, sb2.pop_front()});
        end
      end else if (!prev_n2 && !psg_wr_n2) begin
        low_cnt2++;
      end else if (!prev_n2 && psg_wr_n2) begin
        chk("fast_low_width", low_cnt2, 1);
      end
      prev_n2 = psg_wr_n2;
    end
  end

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic       clr;
    logic       acc;
    logic [3:0] lvl;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t tbl[13];
  int   exp_lvl[13] = '{1, 1, 2, 3, 4, 5, 5, 6, 7, 8, 8, 7, 7};

  initial begin
    // Fill: 11 writes into an idle queue (FSM pops twice along the way),
    // the 11th finds it full; then write+clear while full; then clear alone.
    for (int i = 0; i < 13; i++) begin
      tbl[i].we   = (i < 12);
      tbl[i].din  = (i == 11) ? 8'hEE : 8'(8'h10 + i);
      tbl[i].clr  = (i >= 11);
      tbl[i].acc  = (i < 10);
      tbl[i].lvl  = 4'(exp_lvl[i]);
      tbl[i].full = (i == 9 || i == 10);
      tbl[i].ovf  = (i == 10 || i == 11);
    end

    // ---- reset state
    repeat (3) step();
    chk("rst_wr_n", psg_wr_n, 1);
    chk("rst_din", psg_din, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();

    // ---- test 1: single write, latency and pulse shape
    cpu_we = 1'b1; cpu_din = 8'h9F; sb.push_back(8'h9F);
    step();
    $display("write dut din=9f");
    cpu_we = 1'b0;
    chk("t1_level_after_push", level, 1);
    step();
    chk("t1_din_setup", psg_din, 8'h9F);
    chk("t1_wr_n_setup", psg_wr_n, 1);
    chk("t1_level_after_pop", level, 0);
    step();
    chk("t1_wr_n_low0", psg_wr_n, 0);
    step();
    chk("t1_wr_n_low1", psg_wr_n, 0);
    step();
    chk("t1_wr_n_high", psg_wr_n, 1);
    repeat (4) step();
    chk("t1_empty", empty, 1);

    // ---- test 2: three-byte burst, 5-cycle cadence
    falls.delete();
    for (int i = 0; i < 3; i++) begin
      cpu_we  = 1'b1;
      cpu_din = (i == 0) ? 8'h80 : (i == 1) ? 8'h0A : 8'h90;
      sb.push_back(cpu_din);
      $display("write dut din=%02h", cpu_din);
      step();
    end
    cpu_we = 1'b0;
    for (int i = 0; i < 40 && falls.size() < 3; i++) step();
    chk("t2_pulse_count", falls.size(), 3);
    if (falls.size() == 3) begin
      chk("t2_spacing_0", falls[1] - falls[0], 5);
      chk("t2_spacing_1", falls[2] - falls[1], 5);
    end
    repeat (8) step();
    chk("t2_level_drained", level, 0);

    // ---- tests 3/4: fill to full, overflow, clear priority
    for (int i = 0; i < 13; i++) begin
      cpu_we  = tbl[i].we;
      cpu_din = tbl[i].din;
      ovf_clr = tbl[i].clr;
      if (tbl[i].acc) sb.push_back(tbl[i].din);
      if (tbl[i].we) $display("write dut din=%02h clr=%0d", tbl[i].din, tbl[i].clr);
      step();
      chk($sformatf("t3_level[%0d]", i), level, tbl[i].lvl);
      chk($sformatf("t3_full[%0d]", i), full, tbl[i].full);
      chk($sformatf("t3_ovf[%0d]", i), overflow, tbl[i].ovf);
    end
    cpu_we = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    chk("t3_all_emitted", sb.size(), 0);
    repeat (8) step();
    chk("t3_empty", empty, 1);
    chk("t3_level_zero", level, 0);

    // ---- test 5: reset during LOW with 4 entries queued
    for (int i = 0; i < 6; i++) begin
      cpu_we = 1'b1; cpu_din = 8'(8'h31 + i);
      sb.push_back(cpu_din);
      $display("write dut din=%02h", cpu_din);
      step();
    end
    cpu_we = 1'b0;
    step();
    step();
    chk("t5_level_before_rst", level, 4);
    chk("t5_low_before_rst", psg_wr_n, 0);
    rst = 1'b1;
    step();
    chk("t5_wr_n_after_rst", psg_wr_n, 1);
    chk("t5_din_after_rst", psg_din, 0);
    chk("t5_level_after_rst", level, 0);
    chk("t5_empty_after_rst", empty, 1);
    sb.delete();
    step();
    rst = 1'b0;
    begin
      int n;
      n = falls.size();
      repeat (20) step();
      chk("t5_no_more_pulses", falls.size(), n);
      chk("t5_level_stays_zero", level, 0);
    end

    // ---- test 6: PULSE=1, GAP=1 instance, 3-cycle cadence
    falls2.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_we2 = 1'b1; cpu_din2 = 8'(8'hA1 + i);
      sb2.push_back(cpu_din2);
      $display("write dut_fast din=%02h", cpu_din2);
      step();
    end
    cpu_we2 = 1'b0;
    for (int i = 0; i < 40 && falls2.size() < 4; i++) step();
    chk("t6_pulse_count", falls2.size(), 4);
    if (falls2.size() == 4) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("t6_spacing_%0d", i), falls2[i + 1] - falls2[i], 3);
    end
    repeat (6) step();
    chk("t6_all_registered", sb2.size(), 0);
    chk("t6_level_zero", level2, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
